// File: rtl/fetch_unit_if.sv
// Fetch-to-IMEM/decode bundle: IMEM address/data, redirect request, and the
// registered fetch output with its valid/ready handshake.
interface fetch_unit_if #(
  parameter int INST_WIDTH_LENGTH = 32,
  parameter int PC_WIDTH_LENGTH   = 32
);
  logic [PC_WIDTH_LENGTH-1:0]   pc_out;
  logic [INST_WIDTH_LENGTH-1:0] inst;
  logic                         redirect_valid;
  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc;
  logic [INST_WIDTH_LENGTH-1:0] inst_q;
  logic [PC_WIDTH_LENGTH-1:0]   pc_q;
  logic                         inst_valid;
  logic                         inst_ready;
  logic                         misalign_exc;
  logic [PC_WIDTH_LENGTH-1:0]   fault_pc;
  logic                         stall;

  modport master (
    output pc_out, inst_q, pc_q, inst_valid, misalign_exc, fault_pc, stall,
    input  inst, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  pc_out, inst_q, pc_q, inst_valid, misalign_exc, fault_pc, stall,
    output inst, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers IMEM read data toward decode,
// and handles redirects, trapping misaligned targets to a fixed vector.
module fetch_unit #(
  parameter int                         INST_WIDTH_LENGTH = 32,
  parameter int                         PC_WIDTH_LENGTH   = 32,
  parameter logic [PC_WIDTH_LENGTH-1:0] RESET_PC          = 32'h0000_0000,
  parameter logic [PC_WIDTH_LENGTH-1:0] TRAP_VEC          = 32'h0000_0100
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {BOOT, RUN, STALL, TRAP} state_t;

  localparam logic [INST_WIDTH_LENGTH-1:0] NOP = INST_WIDTH_LENGTH'(32'h0000_0013);

  state_t                       state_q, state_d;
  logic [PC_WIDTH_LENGTH-1:0]   pc_out_q, pc_out_d;
  logic [PC_WIDTH_LENGTH-1:0]   pc_buf_q, pc_buf_d;
  logic [PC_WIDTH_LENGTH-1:0]   fault_pc_q, fault_pc_d;
  logic [INST_WIDTH_LENGTH-1:0] inst_buf_q, inst_buf_d;
  logic                         valid_q, valid_d;
  logic                         exc_q, exc_d;
  logic                         accept;
  logic                         capture;

  always_comb begin
    accept     = !valid_q || bus.inst_ready;
    capture    = 1'b0;
    state_d    = state_q;
    pc_out_d   = pc_out_q;
    pc_buf_d   = pc_buf_q;
    fault_pc_d = fault_pc_q;
    inst_buf_d = inst_buf_q;
    valid_d    = valid_q;
    exc_d      = 1'b0;

    // A redirect wins over every state; a misaligned target never reaches IMEM.
    if (bus.redirect_valid) begin
      valid_d = 1'b0;
      if (bus.redirect_pc[1:0] == 2'b00) begin
        pc_out_d = bus.redirect_pc;
        state_d  = RUN;
      end else begin
        pc_out_d   = TRAP_VEC;
        fault_pc_d = bus.redirect_pc;
        exc_d      = 1'b1;
        state_d    = TRAP;
      end
    end else begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN: begin
          if (accept) capture = 1'b1;
          else        state_d = STALL;
        end
        STALL: begin
          if (bus.inst_ready) begin
            capture = 1'b1;
            state_d = RUN;
          end
        end
        TRAP:    state_d = RUN;
        default: state_d = BOOT;
      endcase

      if (capture) begin
        inst_buf_d = bus.inst;
        pc_buf_d   = pc_out_q;
        valid_d    = 1'b1;
        pc_out_d   = pc_out_q + PC_WIDTH_LENGTH'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_out_q   <= RESET_PC;
      pc_buf_q   <= '0;
      fault_pc_q <= '0;
      inst_buf_q <= NOP;
      valid_q    <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_out_q   <= pc_out_d;
      pc_buf_q   <= pc_buf_d;
      fault_pc_q <= fault_pc_d;
      inst_buf_q <= inst_buf_d;
      valid_q    <= valid_d;
      exc_q      <= exc_d;
    end
  end

  assign bus.pc_out       = pc_out_q;
  assign bus.inst_q       = inst_buf_q;
  assign bus.pc_q         = pc_buf_q;
  assign bus.inst_valid   = valid_q;
  assign bus.misalign_exc = exc_q;
  assign bus.fault_pc     = fault_pc_q;
  assign bus.stall        = (state_q == STALL);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table for the fetch scenarios, an async
// reset probe, then randomized traffic against a cycle-level reference model.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   passCount;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // IMEM word k holds 32'h1000_0000 + k
  function automatic logic [31:0] imem(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign bus.inst = imem(bus.pc_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        expValid;
    logic [31:0] expPcq;
    logic [31:0] expPcOut;
    logic        expStall;
    logic        expExc;
    logic [31:0] expFault;
  } vec_t;

  vec_t vecs [21];

  // Reference model: counts no-capture cycles instead of tracking FSM states
  logic [31:0] mPc, mPcq, mInst, mFault;
  logic        mValid, mExc, mStall;
  int          mSkip;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  task automatic applyStimulus(input logic ready, input logic rv, input logic [31:0] rpc);
    bus.inst_ready     = ready;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic checkOutput(input string tag, input logic expValid, input logic [31:0] expPcq,
                             input logic [31:0] expInst, input logic [31:0] expPcOut,
                             input logic expStall, input logic expExc, input logic [31:0] expFault);
    check({tag, ".inst_valid"},   {31'b0, bus.inst_valid},   {31'b0, expValid});
    check({tag, ".pc_q"},         bus.pc_q,                  expPcq);
    check({tag, ".inst_q"},       bus.inst_q,                expInst);
    check({tag, ".pc_out"},       bus.pc_out,                expPcOut);
    check({tag, ".stall"},        {31'b0, bus.stall},        {31'b0, expStall});
    check({tag, ".misalign_exc"}, {31'b0, bus.misalign_exc}, {31'b0, expExc});
    check({tag, ".fault_pc"},     bus.fault_pc,              expFault);
  endtask

  task automatic modelReset();
    mPc = 32'h0; mPcq = 32'h0; mInst = 32'h13; mFault = 32'h0;
    mValid = 1'b0; mExc = 1'b0; mStall = 1'b0; mSkip = 1;
  endtask

  task automatic modelStep(input logic ready, input logic rv, input logic [31:0] rpc);
    mExc   = 1'b0;
    mStall = 1'b0;
    if (rv) begin
      mValid = 1'b0;
      if (rpc[1:0] == 2'b00) begin
        mPc   = rpc;
        mSkip = 0;
      end else begin
        mPc    = 32'h0000_0100;
        mFault = rpc;
        mExc   = 1'b1;
        mSkip  = 1;
      end
    end else if (mSkip > 0) begin
      mSkip--;
    end else if (!mValid || ready) begin
      mInst  = imem(mPc);
      mPcq   = mPc;
      mValid = 1'b1;
      mPc    = mPc + 32'd4;
    end else begin
      mStall = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] rpc;
    logic        ready;
    logic        rv;
    checkCount = 0;
    passCount  = 0;

    vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         32'h4,         1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         32'h8,         1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'hC,         1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         32'hC,         1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         32'hC,         1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         32'hC,         1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         32'h10,        1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h10,        32'h14,        1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 32'h40,        1'b0, 32'h10,        32'h40,        1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h40,        32'h44,        1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h44,        32'h48,        1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b1, 32'h42,        1'b0, 32'h44,        32'h100,       1'b0, 1'b1, 32'h42};
    vecs[13] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h44,        32'h100,       1'b0, 1'b0, 32'h42};
    vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h100,       32'h104,       1'b0, 1'b0, 32'h42};
    vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       32'h104,       1'b1, 1'b0, 32'h42};
    vecs[16] = '{1'b0, 1'b1, 32'h200,       1'b0, 32'h100,       32'h200,       1'b0, 1'b0, 32'h42};
    vecs[17] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h200,       32'h204,       1'b0, 1'b0, 32'h42};
    vecs[18] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h200,       32'hFFFF_FFFC, 1'b0, 1'b0, 32'h42};
    vecs[19] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0,         1'b0, 1'b0, 32'h42};
    vecs[20] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         32'h4,         1'b0, 1'b0, 32'h42};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("reset", 1'b0, 32'h0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].ready, vecs[i].rv, vecs[i].rpc);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPcq,
                  (i == 0) ? 32'h13 : imem(vecs[i].expPcq), vecs[i].expPcOut,
                  vecs[i].expStall, vecs[i].expExc, vecs[i].expFault);
    end

    // Async reset between edges while streaming
    applyStimulus(1'b1, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 1'b0, 32'h0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    for (int n = 0; n < 400; n++) begin
      ready = ($urandom_range(0, 3) != 0);
      rv    = ($urandom_range(0, 7) == 0);
      rpc   = $urandom;
      case ($urandom_range(0, 3))
        0: if (rpc[1:0] == 2'b00) rpc[0] = 1'b1;
        1: rpc = 32'hFFFF_FFF0 | {28'b0, rpc[3:2], 2'b00};
        default: rpc[1:0] = 2'b00;
      endcase
      applyStimulus(ready, rv, rpc);
      @(posedge clk);
      modelStep(ready, rv, rpc);
      @(negedge clk);
      checkOutput($sformatf("rand%0d", n), mValid, mPcq, mInst, mPc, mStall, mExc, mFault);
      check($sformatf("rand%0d.pc_align", n), {30'b0, bus.pc_out[1:0]}, 32'h0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
